ur_mem_arb: RTL and testbench

UR_MEM_ARB -- requirements
Module: uriscv_mem_arb

---
 rtl/ur_mem_arb.sv | 161 ++++++++++++++++
 tb/tb_ur_mem_arb.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ur_mem_arb.sv
// ur_mem_arb: arbitrates a fetch port and an LSU port onto one memory bus,
// with at most one memory transaction outstanding.
// Build option: define URISCV_ARB_ROUND_ROBIN_EN to alternate grants on
// contention; otherwise the LSU always wins over fetch.
module ur_mem_arb (
  input  logic        clk_i,
  input  logic        rst_i,
  // fetch side
  input  logic        fetch_rd_i,
  input  logic [31:0] fetch_pc_i,
  output logic        fetch_accept_o,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  // LSU side
  input  logic        lsu_rd_i,
  input  logic [3:0]  lsu_wr_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  input  logic        lsu_misaligned_i,
  output logic        lsu_accept_o,
  output logic        lsu_ack_o,
  output logic        lsu_error_o,
  output logic [31:0] lsu_data_o,
  // memory side
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        mem_rd_q;
  logic [3:0]  mem_wr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        grant_lsu_q;
  logic        fetch_valid_q;
  logic [31:0] fetch_instr_q;
  logic        lsu_ack_q;
  logic        lsu_error_q;
  logic [31:0] lsu_data_q;
`ifdef URISCV_ARB_ROUND_ROBIN_EN
  logic        last_lsu_q;
`endif

  logic lsu_pend;
  logic fetch_pend;
  logic can_grant;
  logic pick_lsu;
  logic complete;

  // Grant selection; a response pulse cycle doubles as the post-transaction idle gap.
  always_comb begin
    lsu_pend   = lsu_rd_i | (|lsu_wr_i);
    fetch_pend = fetch_rd_i;
    can_grant  = (state_q == ST_IDLE) & ~rst_i & ~fetch_valid_q & ~lsu_ack_q;
`ifdef URISCV_ARB_ROUND_ROBIN_EN
    pick_lsu   = lsu_pend & (~fetch_pend | ~last_lsu_q);
`else
    pick_lsu   = lsu_pend;
`endif
    lsu_accept_o   = can_grant & pick_lsu;
    fetch_accept_o = can_grant & fetch_pend & ~pick_lsu;
    complete       = ((state_q == ST_REQ) & mem_accept_i & mem_ack_i) |
                     ((state_q == ST_RESP) & mem_ack_i);
  end

  // Arbiter FSM, memory request registers and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 4'd0;
      mem_addr_q    <= 32'd0;
      mem_data_q    <= 32'd0;
      grant_lsu_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= 32'd0;
      lsu_ack_q     <= 1'b0;
      lsu_error_q   <= 1'b0;
      lsu_data_q    <= 32'd0;
`ifdef URISCV_ARB_ROUND_ROBIN_EN
      last_lsu_q    <= 1'b0;
`endif
    end else begin
      fetch_valid_q <= 1'b0;
      lsu_ack_q     <= 1'b0;
      lsu_error_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lsu_accept_o || fetch_accept_o) begin
            grant_lsu_q <= lsu_accept_o;
`ifdef URISCV_ARB_ROUND_ROBIN_EN
            last_lsu_q  <= lsu_accept_o;
`endif
            if (lsu_accept_o && lsu_misaligned_i) begin
              lsu_ack_q   <= 1'b1;
              lsu_error_q <= 1'b1;
            end else if (lsu_accept_o) begin
              mem_rd_q   <= lsu_rd_i;
              mem_wr_q   <= lsu_wr_i;
              mem_addr_q <= lsu_addr_i;
              mem_data_q <= lsu_data_i;
              state_q    <= ST_REQ;
            end else begin
              mem_rd_q   <= 1'b1;
              mem_wr_q   <= 4'd0;
              mem_addr_q <= fetch_pc_i;
              mem_data_q <= 32'd0;
              state_q    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_accept_i) begin
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 4'd0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
            state_q    <= mem_ack_i ? ST_IDLE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_ack_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (complete) begin
        if (grant_lsu_q) begin
          lsu_ack_q  <= 1'b1;
          lsu_data_q <= mem_data_i;
        end else begin
          fetch_valid_q <= 1'b1;
          fetch_instr_q <= mem_data_i;
        end
      end
    end
  end

  assign mem_rd_o      = mem_rd_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_instr_o = fetch_instr_q;
  assign lsu_ack_o     = lsu_ack_q;
  assign lsu_error_o   = lsu_error_q;
  assign lsu_data_o    = lsu_data_q;

endmodule

// File: tb/tb_ur_mem_arb.sv
// Testbench for ur_mem_arb: directed timing cases plus randomized traffic
// against a word-level memory model, with a queue-based scoreboard.
module tb_ur_mem_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_rd_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_accept_o, fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic        lsu_rd_i;
  logic [3:0]  lsu_wr_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic        lsu_misaligned_i;
  logic        lsu_accept_o, lsu_ack_o, lsu_error_o;
  logic [31:0] lsu_data_o;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_accept_i, mem_ack_i;
  logic [31:0] mem_data_i;

  // memory inputs come either from the directed code or the random slave
  logic        slave_en = 1'b0;
  logic        m_accept = 1'b0, m_ack = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        s_accept = 1'b0, s_ack = 1'b0;
  logic [31:0] s_data = 32'd0;
  assign mem_accept_i = slave_en ? s_accept : m_accept;
  assign mem_ack_i    = slave_en ? s_ack    : m_ack;
  assign mem_data_i   = slave_en ? s_data   : m_data;

  ur_mem_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_rd_i(fetch_rd_i), .fetch_pc_i(fetch_pc_i),
    .fetch_accept_o(fetch_accept_o), .fetch_valid_o(fetch_valid_o),
    .fetch_instr_o(fetch_instr_o),
    .lsu_rd_i(lsu_rd_i), .lsu_wr_i(lsu_wr_i), .lsu_addr_i(lsu_addr_i),
    .lsu_data_i(lsu_data_i), .lsu_misaligned_i(lsu_misaligned_i),
    .lsu_accept_o(lsu_accept_o), .lsu_ack_o(lsu_ack_o),
    .lsu_error_o(lsu_error_o), .lsu_data_o(lsu_data_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_accept_i(mem_accept_i),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] data; logic err; } lsu_exp_t;
  typedef struct packed { logic rd; logic [3:0] wr; logic [31:0] addr; logic [31:0] data; } cmd_t;

  logic [31:0] exp_f[$];
  lsu_exp_t    exp_l[$];
  cmd_t        exp_cmd[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] sl_mem[logic [31:0]];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] pred_lsu = 32'd0;
  logic [31:0] last_f = 32'd0;
  logic [31:0] last_l = 32'd0;
`ifdef URISCV_ARB_ROUND_ROBIN_EN
  logic        last_lsu = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got event, required none (t=%0t)", nm, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic samp();
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] w = a & ~32'd3;
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] cur = ref_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[a & ~32'd3] = cur;
  endfunction

  function automatic logic [31:0] sl_rd(input logic [31:0] a);
    logic [31:0] w = a & ~32'd3;
    return sl_mem.exists(w) ? sl_mem[w] : init_word(w);
  endfunction

  function automatic void sl_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] cur = sl_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = d[8*b +: 8];
    sl_mem[a & ~32'd3] = cur;
  endfunction

  // Monitor: grant rule, response scoreboard and output hold checks.
  initial begin : monitor
    logic pf, pl, want_l;
    logic [31:0] ef;
    lsu_exp_t el;
    forever begin
      samp();
      if (rst_i) begin
        chk("accept_in_reset", 32'({fetch_accept_o, lsu_accept_o}), 32'd0);
        exp_f.delete(); exp_l.delete(); exp_cmd.delete();
        last_f = 32'd0; last_l = 32'd0; pred_lsu = 32'd0;
`ifdef URISCV_ARB_ROUND_ROBIN_EN
        last_lsu = 1'b0;
`endif
      end else begin
        if (fetch_accept_o || lsu_accept_o) begin
          pf = fetch_rd_i;
          pl = lsu_rd_i || (lsu_wr_i != 4'd0);
`ifdef URISCV_ARB_ROUND_ROBIN_EN
          want_l = pl && (!pf || !last_lsu);
          if (pf || pl) last_lsu = want_l;
`else
          want_l = pl;
`endif
          chk("grant_select", 32'({fetch_accept_o, lsu_accept_o}), 32'({pf && !want_l, want_l}));
        end
        if (fetch_valid_o) begin
          if (exp_f.size() == 0) fail_evt("fetch_valid_unexpected");
          else begin
            ef = exp_f.pop_front();
            chk("fetch_instr", fetch_instr_o, ef);
            last_f = ef;
          end
        end else chk("fetch_instr_hold", fetch_instr_o, last_f);
        if (lsu_ack_o) begin
          if (exp_l.size() == 0) fail_evt("lsu_ack_unexpected");
          else begin
            el = exp_l.pop_front();
            chk("lsu_data", lsu_data_o, el.data);
            chk1("lsu_error", lsu_error_o, el.err);
            last_l = el.data;
          end
        end else begin
          chk("lsu_data_hold", lsu_data_o, last_l);
          chk1("lsu_error_idle", lsu_error_o, 1'b0);
        end
      end
    end
  end

  // Random memory slave: checks each command against the expected one.
  initial begin : mem_slave
    int sphase = 0;
    int acc_cnt = 0;
    int ack_cnt = 0;
    logic [31:0] sl_addr = 32'd0;
    cmd_t ec = '0;
    forever begin
      step();
      if (slave_en) begin
        s_accept = 1'b0;
        s_ack    = 1'b0;
        s_data   = $urandom;
        if (sphase == 2) begin
          ack_cnt--;
          if (ack_cnt == 0) begin
            s_ack  = 1'b1;
            s_data = sl_rd(sl_addr);
            sphase = 0;
          end
        end else begin
          if (sphase == 0 && (mem_rd_o || mem_wr_o != 4'd0)) begin
            if (exp_cmd.size() == 0) begin
              fail_evt("mem_cmd_unexpected");
              ec = '0;
            end else ec = exp_cmd.pop_front();
            acc_cnt = $urandom_range(0, 2);
            ack_cnt = $urandom_range(0, 3);
            sphase  = 1;
          end
          if (sphase == 1) begin
            chk1("mem_rd", mem_rd_o, ec.rd);
            chk("mem_wr", 32'(mem_wr_o), 32'(ec.wr));
            chk("mem_addr", mem_addr_o, ec.addr);
            chk("mem_data", mem_data_o, ec.data);
            if (acc_cnt == 0) begin
              s_accept = 1'b1;
              sl_addr  = mem_addr_o;
              if (mem_wr_o != 4'd0) sl_wr(mem_addr_o, mem_wr_o, mem_data_o);
              if (ack_cnt == 0) begin
                s_ack  = 1'b1;
                s_data = sl_rd(sl_addr);
                sphase = 0;
              end else sphase = 2;
            end else begin
              acc_cnt--;
              s_ack = 1'($urandom_range(0, 1));
            end
          end else s_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic do_reset();
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    int w = 0;
    step();
    fetch_rd_i = 1'b1; fetch_pc_i = pc;
    samp();
    while (!fetch_accept_o && w < 300) begin samp(); w++; end
    if (!fetch_accept_o) fail_evt("fetch_accept_timeout");
    else begin
      exp_f.push_back(ref_rd(pc));
      exp_cmd.push_back('{1'b1, 4'd0, pc, 32'd0});
    end
  endtask

  task automatic do_lsu(input logic rd, input logic [3:0] wr, input logic [31:0] a,
                        input logic [31:0] d, input logic mis);
    int w = 0;
    logic [31:0] rv;
    step();
    lsu_rd_i = rd; lsu_wr_i = wr; lsu_addr_i = a; lsu_data_i = d; lsu_misaligned_i = mis;
    samp();
    while (!lsu_accept_o && w < 300) begin samp(); w++; end
    if (!lsu_accept_o) fail_evt("lsu_accept_timeout");
    else if (mis) exp_l.push_back('{pred_lsu, 1'b1});
    else begin
      if (wr != 4'd0) ref_wr(a, wr, d);
      rv = ref_rd(a);
      exp_l.push_back('{rv, 1'b0});
      pred_lsu = rv;
      exp_cmd.push_back('{rd, wr, a, d});
    end
  endtask

  task automatic fetch_loop(input int n);
    for (int i = 0; i < n; i++) begin
      do_fetch(32'h1000 + 32'($urandom_range(0, 15)) * 32'd4);
      step(); fetch_rd_i = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic lsu_loop(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
      if ($urandom_range(0, 7) == 0) do_lsu(1'b1, 4'd0, a + 32'd1, 32'd0, 1'b1);
      else if ($urandom_range(0, 1) == 0) do_lsu(1'b1, 4'd0, a, 32'd0, 1'b0);
      else do_lsu(1'b0, 4'($urandom_range(1, 15)), a, $urandom, 1'b0);
      step(); lsu_rd_i = 1'b0; lsu_wr_i = 4'd0; lsu_misaligned_i = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin : main
    logic grants[8];
    int gi, lcnt, fcnt, w;
    fetch_rd_i = 1'b0; fetch_pc_i = 32'd0;
    lsu_rd_i = 1'b0; lsu_wr_i = 4'd0; lsu_addr_i = 32'd0; lsu_data_i = 32'd0;
    lsu_misaligned_i = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // reset state
    samp();
    chk1("rst_mem_rd", mem_rd_o, 1'b0);
    chk("rst_mem_wr", 32'(mem_wr_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk1("rst_fetch_valid", fetch_valid_o, 1'b0);
    chk("rst_fetch_instr", fetch_instr_o, 32'd0);
    chk1("rst_lsu_ack", lsu_ack_o, 1'b0);
    chk1("rst_lsu_error", lsu_error_o, 1'b0);
    chk("rst_lsu_data", lsu_data_o, 32'd0);

    // zero-wait fetch, then back-to-back request period
    m_accept = 1'b1; m_ack = 1'b1; m_data = 32'h0000_0013;
    step(); fetch_rd_i = 1'b1; fetch_pc_i = 32'h8000_0000;
    samp(); chk1("f_accept_N", fetch_accept_o, 1'b1); exp_f.push_back(32'h0000_0013);
    step(); samp();
    chk1("f_mem_rd_N1", mem_rd_o, 1'b1);
    chk("f_mem_addr_N1", mem_addr_o, 32'h8000_0000);
    chk1("f_accept_N1", fetch_accept_o, 1'b0);
    step(); samp();
    chk1("f_valid_N2", fetch_valid_o, 1'b1);
    chk("f_instr_N2", fetch_instr_o, 32'h0000_0013);
    chk1("f_accept_N2", fetch_accept_o, 1'b0);
    chk1("f_mem_rd_N2", mem_rd_o, 1'b0);
    step(); samp();
    chk1("f_accept_N3", fetch_accept_o, 1'b1); exp_f.push_back(32'h0000_0013);
    step(); fetch_rd_i = 1'b0;
    repeat (3) step();

    // store with delayed accept and delayed ack
    m_accept = 1'b0; m_ack = 1'b0; m_data = 32'h5555_AAAA;
    step(); lsu_wr_i = 4'b0100; lsu_addr_i = 32'h1002; lsu_data_i = 32'h00AB_0000;
    samp(); chk1("st_accept", lsu_accept_o, 1'b1);
    exp_l.push_back('{32'h5555_AAAA, 1'b0}); pred_lsu = 32'h5555_AAAA;
    step(); lsu_wr_i = 4'd0; lsu_addr_i = 32'd0; lsu_data_i = 32'd0;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("st_mem_wr", 32'(mem_wr_o), 32'h4);
      chk("st_mem_addr", mem_addr_o, 32'h1002);
      chk("st_mem_data", mem_data_o, 32'h00AB_0000);
      chk1("st_mem_rd", mem_rd_o, 1'b0);
      step();
      if (i == 1) m_accept = 1'b1;
      if (i == 2) m_accept = 1'b0;
    end
    samp(); chk("st_mem_wr_resp", 32'(mem_wr_o), 32'd0);
    step(); step(); m_ack = 1'b1;
    samp(); chk1("st_ack_early", lsu_ack_o, 1'b0);
    step(); m_ack = 1'b0;
    samp(); chk1("st_ack_pulse", lsu_ack_o, 1'b1); chk1("st_err", lsu_error_o, 1'b0);
    step(); samp(); chk1("st_ack_once", lsu_ack_o, 1'b0);

    // misaligned load aborts without memory access
    step(); lsu_rd_i = 1'b1; lsu_misaligned_i = 1'b1; lsu_addr_i = 32'h1001;
    samp(); chk1("mis_accept", lsu_accept_o, 1'b1); exp_l.push_back('{pred_lsu, 1'b1});
    step(); lsu_rd_i = 1'b0; lsu_misaligned_i = 1'b0; lsu_addr_i = 32'd0;
    samp();
    chk1("mis_ack", lsu_ack_o, 1'b1); chk1("mis_err", lsu_error_o, 1'b1);
    chk1("mis_mem_rd", mem_rd_o, 1'b0);
    step(); samp();
    chk1("mis_ack_end", lsu_ack_o, 1'b0); chk1("mis_err_end", lsu_error_o, 1'b0);
    chk1("mis_mem_rd_end", mem_rd_o, 1'b0);

    // contention: four transactions held on each side
    do_reset();
    m_accept = 1'b1; m_ack = 1'b1; m_data = 32'hCAFE_0001;
    step(); lsu_rd_i = 1'b1; lsu_addr_i = 32'h1000; fetch_rd_i = 1'b1; fetch_pc_i = 32'h1004;
    gi = 0; lcnt = 4; fcnt = 4; w = 0;
    while (gi < 8 && w < 100) begin
      samp();
      if (lsu_accept_o) begin
        grants[gi] = 1'b1; gi++; lcnt--;
        exp_l.push_back('{32'hCAFE_0001, 1'b0}); pred_lsu = 32'hCAFE_0001;
      end else if (fetch_accept_o) begin
        grants[gi] = 1'b0; gi++; fcnt--;
        exp_f.push_back(32'hCAFE_0001);
      end
      step();
      if (lcnt == 0) lsu_rd_i = 1'b0;
      if (fcnt == 0) fetch_rd_i = 1'b0;
      w++;
    end
    lsu_rd_i = 1'b0; fetch_rd_i = 1'b0;
    chk("cont_grant_count", 32'(gi), 32'd8);
    for (int i = 0; i < gi; i++) begin
`ifdef URISCV_ARB_ROUND_ROBIN_EN
      chk1($sformatf("cont_grant_%0d", i), grants[i], (i % 2) == 0);
`else
      chk1($sformatf("cont_grant_%0d", i), grants[i], i < 4);
`endif
    end
    repeat (3) step();

    // reset while waiting for the response, then a stale ack
    m_accept = 1'b0; m_ack = 1'b0;
    step(); fetch_rd_i = 1'b1; fetch_pc_i = 32'h2000;
    samp(); chk1("rr_accept", fetch_accept_o, 1'b1);
    step(); fetch_rd_i = 1'b0; m_accept = 1'b1;
    step(); m_accept = 1'b0;
    step(); rst_i = 1'b1; fetch_rd_i = 1'b1;
    samp(); chk1("rr_accept_in_reset", fetch_accept_o, 1'b0);
    step(); rst_i = 1'b0; fetch_rd_i = 1'b0;
    step(); step(); m_ack = 1'b1; m_data = 32'h1234_5678;
    step(); m_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk1("rr_fetch_valid", fetch_valid_o, 1'b0);
      chk1("rr_lsu_ack", lsu_ack_o, 1'b0);
      chk1("rr_mem_rd", mem_rd_o, 1'b0);
      chk("rr_mem_addr", mem_addr_o, 32'd0);
      chk("rr_fetch_instr", fetch_instr_o, 32'd0);
      step();
    end
    m_accept = 1'b1; m_ack = 1'b1; m_data = 32'h0000_0077;
    fetch_rd_i = 1'b1; fetch_pc_i = 32'h3000;
    samp(); chk1("rr_idle_accept", fetch_accept_o, 1'b1); exp_f.push_back(32'h0000_0077);
    step(); fetch_rd_i = 1'b0;
    repeat (3) step();

    // randomized traffic against the memory model
    do_reset();
    slave_en = 1'b1;
    fork
      fetch_loop(40);
      lsu_loop(40);
    join
    w = 0;
    while ((exp_f.size() != 0 || exp_l.size() != 0) && w < 300) begin samp(); w++; end
    chk("drain_fetch", 32'(exp_f.size()), 32'd0);
    chk("drain_lsu", 32'(exp_l.size()), 32'd0);
    chk("drain_cmd", 32'(exp_cmd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
